// File: rtl/mdu_iterative.sv
// rtl/mdu_iterative.sv - iterative RV M-extension multiply/divide unit for the EX stage
// Optional early-out for trivial operands: define MDU_EARLY_OUT_EN.
module mdu_iterative #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  logic [2:0]       i_funct3,
    input  logic [XLEN-1:0]  i_rs1,
    input  logic [XLEN-1:0]  i_rs2,
    input  logic [TAG_W-1:0] i_tag,
    input  logic             i_flush,
    output logic             o_busy,
    output logic             o_done,
    output logic [XLEN-1:0]  o_result,
    output logic [TAG_W-1:0] o_tag
);

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state;
    logic [2:0]         f3_q;
    logic [TAG_W-1:0]   tag_q;
    logic               s1_q;
    logic               s2_q;
    logic               div0_q;
    logic [XLEN-1:0]    op_b;
    logic [XLEN-1:0]    acc;
    logic [XLEN-1:0]    lo;
    logic [CNT_W-1:0]   cnt;

    logic               is_div_in;
    logic               s1_in;
    logic               s2_in;
    logic               div0_in;
    logic [XLEN-1:0]    abs1;
    logic [XLEN-1:0]    abs2;

    always_comb begin
        is_div_in = i_funct3[2];
        s1_in     = 1'b0;
        s2_in     = 1'b0;
        case (i_funct3)
            3'd1, 3'd4, 3'd6: begin
                s1_in = i_rs1[XLEN-1];
                s2_in = i_rs2[XLEN-1];
            end
            3'd2:    s1_in = i_rs1[XLEN-1];
            default: ;
        endcase
        abs1    = s1_in ? (~i_rs1 + 1'b1) : i_rs1;
        abs2    = s2_in ? (~i_rs2 + 1'b1) : i_rs2;
        div0_in = is_div_in && (i_rs2 == '0);
    end

`ifdef MDU_EARLY_OUT_EN
    logic ovf_in;
    logic early_in;

    always_comb begin
        ovf_in   = (i_funct3 == 3'd4 || i_funct3 == 3'd6)
                   && (i_rs1 == {1'b1, {(XLEN-1){1'b0}}})
                   && (i_rs2 == {XLEN{1'b1}});
        early_in = div0_in || ovf_in
                   || (!is_div_in && (i_rs1 == '0 || i_rs2 == '0));
    end
`endif

    // Multiply: {acc, lo} is the product shifting right, lo starts as the multiplier.
    // Divide: lo shifts the dividend out and the quotient in, acc is the partial remainder.
    logic [XLEN:0]      mul_sum;
    logic [XLEN:0]      div_shift;
    logic [XLEN:0]      div_diff;

    always_comb begin
        mul_sum   = {1'b0, acc} + (lo[0] ? {1'b0, op_b} : {(XLEN+1){1'b0}});
        div_shift = {acc, lo[XLEN-1]};
        div_diff  = div_shift - {1'b0, op_b};
    end

    logic [2*XLEN-1:0]  prod;
    logic [2*XLEN-1:0]  prod_fix;
    logic [XLEN-1:0]    quot_fix;
    logic [XLEN-1:0]    rem_fix;
    logic [XLEN-1:0]    result_sel;

    // A zero divisor must yield all ones regardless of the dividend sign.
    always_comb begin
        prod     = {acc, lo};
        prod_fix = (s1_q ^ s2_q) ? (~prod + 1'b1) : prod;
        quot_fix = div0_q ? {XLEN{1'b1}}
                 : ((s1_q ^ s2_q) ? (~lo + 1'b1) : lo);
        rem_fix  = s1_q ? (~acc + 1'b1) : acc;
        case (f3_q)
            3'd0:             result_sel = prod_fix[XLEN-1:0];
            3'd1, 3'd2, 3'd3: result_sel = prod_fix[2*XLEN-1:XLEN];
            3'd4, 3'd5:       result_sel = quot_fix;
            default:          result_sel = rem_fix;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            f3_q     <= '0;
            tag_q    <= '0;
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            div0_q   <= 1'b0;
            op_b     <= '0;
            acc      <= '0;
            lo       <= '0;
            cnt      <= '0;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
            o_result <= '0;
            o_tag    <= '0;
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start && !i_flush) begin
                        f3_q   <= i_funct3;
                        tag_q  <= i_tag;
                        s1_q   <= s1_in;
                        s2_q   <= s2_in;
                        div0_q <= div0_in;
                        op_b   <= abs2;
                        cnt    <= '0;
                        o_busy <= 1'b1;
`ifdef MDU_EARLY_OUT_EN
                        // Preload what the full iteration would leave behind.
                        if (early_in) begin
                            lo    <= is_div_in ? abs1 : '0;
                            acc   <= div0_in ? abs1 : '0;
                            state <= FIX;
                        end else begin
                            lo    <= abs1;
                            acc   <= '0;
                            state <= CALC;
                        end
`else
                        lo     <= abs1;
                        acc    <= '0;
                        state  <= CALC;
`endif
                    end
                end
                CALC: begin
                    if (i_flush) begin
                        o_busy <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        if (f3_q[2]) begin
                            if (!div_diff[XLEN]) begin
                                acc <= div_diff[XLEN-1:0];
                                lo  <= {lo[XLEN-2:0], 1'b1};
                            end else begin
                                acc <= div_shift[XLEN-1:0];
                                lo  <= {lo[XLEN-2:0], 1'b0};
                            end
                        end else begin
                            acc <= mul_sum[XLEN:1];
                            lo  <= {mul_sum[0], lo[XLEN-1:1]};
                        end
                        if (cnt == CNT_LAST) begin
                            cnt   <= '0;
                            state <= FIX;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                FIX: begin
                    o_busy <= 1'b0;
                    if (i_flush) begin
                        state <= IDLE;
                    end else begin
                        o_result <= result_sel;
                        o_tag    <= tag_q;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    o_done <= !i_flush;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_iterative.sv
// tb/tb_mdu_iterative.sv - directed self-checking bench for mdu_iterative
module tb_mdu_iterative;

`ifdef MDU_EARLY_OUT_EN
    localparam int SPECIAL_LAT = 2;
`else
    localparam int SPECIAL_LAT = 34;
`endif
    localparam int FULL_LAT = 34;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        i_start = 1'b0;
    logic [2:0]  i_funct3 = '0;
    logic [31:0] i_rs1 = '0;
    logic [31:0] i_rs2 = '0;
    logic [4:0]  i_tag = '0;
    logic        i_flush = 1'b0;
    logic        o_busy;
    logic        o_done;
    logic [31:0] o_result;
    logic [4:0]  o_tag;

    int checks = 0;
    int errors = 0;
    logic [31:0] last_exp = '0;
    logic [4:0]  last_tag = '0;

    typedef struct packed {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t norm_vecs [12] = '{
        '{3'd0, 32'hFFFFFFFF, 32'h00000003, 32'hFFFFFFFD},
        '{3'd1, 32'hFFFFFFFF, 32'h00000003, 32'hFFFFFFFF},
        '{3'd3, 32'hFFFFFFFF, 32'h00000003, 32'h00000002},
        '{3'd2, 32'hFFFFFFFF, 32'h00000003, 32'hFFFFFFFF},
        '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000},
        '{3'd4, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD},
        '{3'd6, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF},
        '{3'd4, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD},
        '{3'd6, 32'h00000007, 32'hFFFFFFFE, 32'h00000001},
        '{3'd5, 32'd100,      32'd7,        32'd14},
        '{3'd7, 32'd100,      32'd7,        32'd2},
        '{3'd4, 32'h80000000, 32'h00000001, 32'h80000000}
    };

    vec_t spec_vecs [8] = '{
        '{3'd5, 32'h12345678, 32'h00000000, 32'hFFFFFFFF},
        '{3'd7, 32'h12345678, 32'h00000000, 32'h12345678},
        '{3'd4, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFFF},
        '{3'd6, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9},
        '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000},
        '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000},
        '{3'd0, 32'h12345678, 32'h00000000, 32'h00000000},
        '{3'd1, 32'h00000000, 32'h80000000, 32'h00000000}
    };

    always #5 clk = ~clk;

    mdu_iterative #(.XLEN(32), .TAG_W(5)) dut (
        .clk      (clk),
        .reset    (reset),
        .i_start  (i_start),
        .i_funct3 (i_funct3),
        .i_rs1    (i_rs1),
        .i_rs2    (i_rs2),
        .i_tag    (i_tag),
        .i_flush  (i_flush),
        .o_busy   (o_busy),
        .o_done   (o_done),
        .o_result (o_result),
        .o_tag    (o_tag)
    );

    // Drives one op and waits for its done pulse; lat stays -1 on timeout.
    task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] t, output logic [31:0] res,
                         output logic [4:0] tg, output int lat);
        @(negedge clk);
        i_start = 1'b1; i_funct3 = f; i_rs1 = a; i_rs2 = b; i_tag = t;
        @(posedge clk); #1;
        i_start = 1'b0; i_rs1 = 32'hDEADBEEF; i_rs2 = 32'h0BADF00D; i_tag = 5'h1F;
        lat = -1; res = '0; tg = '0;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk); #1;
            if (o_done) begin
                lat = k; res = o_result; tg = o_tag;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #3 reset = 1'b1;
        #1;
        checks++;
        if (o_busy !== 1'b0 || o_done !== 1'b0 || o_result !== 32'h0 || o_tag !== 5'h0) begin
            errors++;
            $display("FAIL reset_state busy=%b done=%b result=%h tag=%h required 0/0/0/0",
                     o_busy, o_done, o_result, o_tag);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;
    endtask

    task automatic test_arith();
        logic [31:0] res; logic [4:0] tg; int lat;
        for (int i = 0; i < 12; i++) begin
            do_op(norm_vecs[i].f, norm_vecs[i].a, norm_vecs[i].b, 5'(i + 1), res, tg, lat);
            last_exp = norm_vecs[i].exp; last_tag = 5'(i + 1);
            checks++;
            if (res !== norm_vecs[i].exp || tg !== 5'(i + 1) || lat != FULL_LAT) begin
                errors++;
                $display("FAIL arith_%0d result=%h tag=%0d lat=%0d required %h/%0d/%0d",
                         i, res, tg, lat, norm_vecs[i].exp, i + 1, FULL_LAT);
            end
        end
    endtask

    task automatic test_special();
        logic [31:0] res; logic [4:0] tg; int lat;
        for (int i = 0; i < 8; i++) begin
            do_op(spec_vecs[i].f, spec_vecs[i].a, spec_vecs[i].b, 5'(i + 16), res, tg, lat);
            last_exp = spec_vecs[i].exp; last_tag = 5'(i + 16);
            checks++;
            if (res !== spec_vecs[i].exp || tg !== 5'(i + 16) || lat != SPECIAL_LAT) begin
                errors++;
                $display("FAIL special_%0d result=%h tag=%0d lat=%0d required %h/%0d/%0d",
                         i, res, tg, lat, spec_vecs[i].exp, i + 16, SPECIAL_LAT);
            end
        end
    endtask

    task automatic test_flush();
        int dones = 0; int lat = -1;
        @(negedge clk);
        i_start = 1'b1; i_funct3 = 3'd5; i_rs1 = 32'd100; i_rs2 = 32'd7; i_tag = 5'd3;
        @(posedge clk); #1 i_start = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (o_done) dones++;
        end
        i_flush = 1'b1;
        @(posedge clk); #1;
        i_flush = 1'b0;
        checks++;
        if (o_busy !== 1'b0 || o_result !== last_exp || o_tag !== last_tag) begin
            errors++;
            $display("FAIL flush_abort busy=%b result=%h tag=%0d required 0/%h/%0d",
                     o_busy, o_result, o_tag, last_exp, last_tag);
        end
        i_start = 1'b1; i_funct3 = 3'd5; i_rs1 = 32'd100; i_rs2 = 32'd7; i_tag = 5'd7;
        @(posedge clk); #1 i_start = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk); #1;
            if (o_done) begin
                lat = k;
                checks++;
                if (o_tag !== 5'd7 || o_result !== 32'd14) begin
                    errors++;
                    $display("FAIL flush_restart result=%h tag=%0d required %h/7",
                             o_result, o_tag, 32'd14);
                end
                break;
            end
        end
        checks++;
        if (dones != 0 || lat != FULL_LAT) begin
            errors++;
            $display("FAIL flush_done_count early_dones=%0d lat=%0d required 0/%0d",
                     dones, lat, FULL_LAT);
        end
        last_exp = 32'd14; last_tag = 5'd7;
    endtask

    task automatic test_busy_ignore();
        int dones = 0; int lat = -1;
        @(negedge clk);
        i_start = 1'b1; i_funct3 = 3'd3; i_rs1 = 32'hFFFFFFFF; i_rs2 = 32'd3; i_tag = 5'd9;
        @(posedge clk); #1;
        i_funct3 = 3'd0; i_rs1 = 32'd5; i_rs2 = 32'd5; i_tag = 5'd10;
        for (int k = 1; k <= 80; k++) begin
            @(posedge clk); #1;
            if (k == 31) i_start = 1'b0;
            if (k == 32 || k == 33) begin
                checks++;
                if (o_busy !== (k == 32)) begin
                    errors++;
                    $display("FAIL busy_edge_%0d busy=%b required %b", k, o_busy, k == 32);
                end
            end
            if (o_done) begin
                dones++;
                if (lat < 0) lat = k;
                checks++;
                if (o_tag !== 5'd9 || o_result !== 32'd2) begin
                    errors++;
                    $display("FAIL busy_result result=%h tag=%0d required 2/9", o_result, o_tag);
                end
            end
        end
        checks++;
        if (dones != 1 || lat != FULL_LAT) begin
            errors++;
            $display("FAIL busy_done_count dones=%0d lat=%0d required 1/%0d",
                     dones, lat, FULL_LAT);
        end
        last_exp = 32'd2; last_tag = 5'd9;
    endtask

    task automatic test_back_to_back();
        int dones = 0; int lat_a = -1; int lat_b = -1;
        @(negedge clk);
        i_start = 1'b1; i_funct3 = 3'd5; i_rs1 = 32'd100; i_rs2 = 32'd7; i_tag = 5'd1;
        @(posedge clk); #1 i_start = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk); #1;
            if (k == 33) begin
                i_start = 1'b1; i_funct3 = 3'd0; i_rs1 = 32'd5; i_rs2 = 32'd6; i_tag = 5'd2;
            end
            if (k == 35) i_start = 1'b0;
            if (o_done) begin
                dones++;
                if (dones == 1) begin
                    lat_a = k;
                    checks++;
                    if (o_result !== 32'd14 || o_tag !== 5'd1) begin
                        errors++;
                        $display("FAIL b2b_first result=%h tag=%0d required %h/1",
                                 o_result, o_tag, 32'd14);
                    end
                end else if (dones == 2) begin
                    lat_b = k;
                    checks++;
                    if (o_result !== 32'd30 || o_tag !== 5'd2) begin
                        errors++;
                        $display("FAIL b2b_second result=%h tag=%0d required %h/2",
                                 o_result, o_tag, 32'd30);
                    end
                end
            end
        end
        checks++;
        if (dones != 2 || lat_a != 34 || lat_b != 69) begin
            errors++;
            $display("FAIL b2b_timing dones=%0d lat_a=%0d lat_b=%0d required 2/34/69",
                     dones, lat_a, lat_b);
        end
    endtask

    task automatic test_reset_mid();
        int dones = 0;
        logic [31:0] res; logic [4:0] tg; int lat;
        @(negedge clk);
        i_start = 1'b1; i_funct3 = 3'd4; i_rs1 = 32'hFFFFFFF9; i_rs2 = 32'd2; i_tag = 5'd12;
        @(posedge clk); #1 i_start = 1'b0;
        repeat (10) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (o_busy !== 1'b0 || o_done !== 1'b0 || o_result !== 32'h0 || o_tag !== 5'h0) begin
            errors++;
            $display("FAIL reset_mid busy=%b done=%b result=%h tag=%h required 0/0/0/0",
                     o_busy, o_done, o_result, o_tag);
        end
        @(negedge clk) reset = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(posedge clk); #1;
            if (o_done) dones++;
        end
        checks++;
        if (dones != 0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_nodone dones=%0d busy=%b required 0/0", dones, o_busy);
        end
        do_op(3'd0, 32'd7, 32'd9, 5'd4, res, tg, lat);
        checks++;
        if (res !== 32'd63 || tg !== 5'd4 || lat != FULL_LAT) begin
            errors++;
            $display("FAIL reset_recover result=%h tag=%0d lat=%0d required %h/4/%0d",
                     res, tg, lat, 32'd63, FULL_LAT);
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_special();
        test_flush();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mdu_iterative.md
Name: mdu_iterative

Overview:
- Parametrised multi-cycle multiply/divide unit for the EX stage of the pipelined core; adds the RV M-extension.
- Replaces single-cycle ALU arithmetic for MUL/DIV-class ops.
- Accepts one operation per start pulse and computes it over XLEN iterations.
- Holds the hazard unit in stall via o_busy; returns a tagged result with a one-cycle done pulse.

Parameters:
- XLEN, 32: operand/result width; any even value ≥ 8.
- TAG_W, 5: width of the destination-register tag carried with the op.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- i_start  input  1  request; sampled only in IDLE
- i_funct3  input  3  op: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- i_rs1  input  XLEN  operand 1 (dividend / multiplicand)
- i_rs2  input  XLEN  operand 2 (divisor / multiplier)
- i_tag  input  TAG_W  destination register tag
- i_flush  input  1  abort in-flight op (EX flush)
- o_busy  output  1  op accepted and not yet done; drives EX stall
- o_done  output  1  one-cycle result-valid pulse
- o_result  output  XLEN  result, valid while o_done
- o_tag  output  TAG_W  tag of the completing op

Behaviour:
- Reset (asynchronous, active-high) values:
  - state = IDLE
  - o_busy = 0, o_done = 0
  - o_result = 0, o_tag = 0
  - all internal registers cleared
- Reset mid-operation discards the op with no done pulse.
- States: IDLE -> CALC -> FIX -> DONE -> IDLE.
- IDLE, start accepted (i_start=1, i_flush=0):
  - latch funct3 and tag
  - latch |rs1| and |rs2| per signedness: MULH signed/signed; MULHSU signed/unsigned; DIV/REM signed; others unsigned
  - latch result-sign flags
  - counter = 0
  - go to CALC
- CALC: exactly XLEN cycles.
  - Multiply: shift-add radix-2 into a 2·XLEN product.
  - Divide: restoring radix-2, one quotient bit per cycle.
  - Counter increments and wraps at XLEN-1, then go to FIX.
- FIX: one cycle.
  - Apply two's-complement sign correction.
  - Select the result:
    - low half for MUL
    - high half for MULH/MULHSU/MULHU
    - quotient for DIV/DIVU
    - remainder for REM/REMU
  - Register o_result.
- DONE: one cycle; o_done = 1 unless i_flush is high that cycle. Next state IDLE.
- Latency: start sampled at edge N; o_done is high in the cycle following edge N+XLEN+2, i.e. XLEN+2 cycles after acceptance.
- o_busy = 1 in CALC and FIX. o_busy = 0 in IDLE and DONE.
- Back-to-back ops: a start in the DONE cycle is ignored; a new op may start in the next cycle (IDLE).
- i_start while not IDLE is ignored. Operands need not be held after acceptance.
- i_flush in CALC/FIX/DONE: state goes to IDLE at the next edge, no done pulse. o_result and o_tag keep their previous values.
- i_flush and i_start together in IDLE: flush wins; start is dropped.
- Division special cases (RISC-V defined, no trap):
  - Divide by zero: quotient = all ones; remainder = dividend.
  - Signed overflow (−2^(XLEN−1) / −1): quotient = dividend; remainder = 0.
- Special-case results are produced by FIX at the normal latency unless MDU_EARLY_OUT_EN is defined.
- o_result and o_tag update only in FIX and hold otherwise.

Optional Feature:
- Macro: MDU_EARLY_OUT_EN.
- When defined, these cases skip CALC:
  - division with rs2 = 0
  - signed division overflow
  - any multiply with rs1 = 0 or rs2 = 0
- Early-out path: IDLE goes straight to FIX, so o_done arrives 2 cycles after acceptance. o_busy is high for the FIX cycle only.
- Results are identical to the full path.
- When not defined, all ops take XLEN+2 cycles; no early-out logic is present.

Test Plan:
- MUL/MULH, XLEN=32:
  - rs1=0xFFFFFFFF (−1), rs2=0x00000003, funct3=0 -> result 0xFFFFFFFD, o_done at +34 cycles.
  - Same operands, funct3=1 -> result 0xFFFFFFFF.
  - Same operands, funct3=3 -> result 0x00000002.
- DIV/REM signed:
  - rs1=−7 (0xFFFFFFF9), rs2=2, funct3=4 -> result 0xFFFFFFFD (−3).
  - Same operands, funct3=6 -> result 0xFFFFFFFF (−1).
- Divide by zero:
  - rs1=0x12345678, rs2=0, DIVU -> 0xFFFFFFFF.
  - Same operands, REMU -> 0x12345678.
  - With MDU_EARLY_OUT_EN: done 2 cycles after acceptance; without it: 34 cycles.
- Overflow: rs1=0x80000000, rs2=0xFFFFFFFF:
  - DIV -> 0x80000000.
  - REM -> 0x00000000.
- Flush mid-op: start DIVU, assert i_flush at cycle 10 -> o_busy=0 at the next edge, no o_done. A new start at cycle 12 with tag 7 completes normally with o_tag=7.
- Busy/reset:
  - i_start pulsed every cycle during CALC -> only the first op completes.
  - Assert reset mid-CALC -> o_busy/o_done/o_result/o_tag = 0 immediately, no done pulse.
